// File: rtl/ahb_pkg.sv
// Shared AHB encodings and data-phase state for the modport_slave codebase slice.
package ahb_pkg;

    typedef enum logic [1:0] {
        TransIdle   = 2'b00,
        TransBusy   = 2'b01,
        TransNonseq = 2'b10,
        TransSeq    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        SizeByte = 3'b000,
        SizeHalf = 3'b001,
        SizeWord = 3'b010
    } hsize_e;

    typedef enum logic [1:0] {
        RespOkay  = 2'b00,
        RespError = 2'b01,
        RespRetry = 2'b10,
        RespSplit = 2'b11
    } hresp_e;

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StOkayDone,
        StErr1,
        StErr2
    } phase_e;

    // Little-endian byte lanes touched by a legal (aligned) transfer.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] offs);
        logic [3:0] m;
        unique case (size)
            2'b00:   m = 4'b0001 << offs;
            2'b01:   m = offs[1] ? 4'b1100 : 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ahb_slave_mem.sv
// Word-organised slave memory: per-byte write enable, combinational read, bulk clear.
module ahb_slave_mem #(
    parameter int unsigned Words = 256,
    parameter int unsigned IdxW  = 8
) (
    input  logic            clk_i,
    input  logic            clear_i,
    input  logic [3:0]      be_i,
    input  logic [IdxW-1:0] addr_i,
    input  logic [31:0]     wdata_i,
    output logic [31:0]     rdata_o
);

    logic [31:0] mem_q [Words];

    // Clear wins over a write so a reset cycle never commits data.
    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            for (int unsigned i = 0; i < Words; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/modport_slave.sv
// AHB slave front end: address-phase capture, wait-state counter and two-cycle error response
// in front of a byte-writable word memory.
module modport_slave
    import ahb_pkg::*;
#(
    parameter int unsigned MEM_WORDS   = 256,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [1:0]  HTRANS,
    input  logic [2:0]  HBURST,
    input  logic [2:0]  HSIZE,
    input  logic        HWRITE,
    input  logic [31:0] HADDR,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    output logic        HREADY,
    output logic [1:0]  HRESP
);

    localparam int unsigned IdxW      = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [32:0] ByteLimit = 33'(MEM_WORDS) << 2;
    localparam logic [2:0]  WaitLoad  = 3'(WAIT_STATES);

    phase_e          phase_q, phase_d;
    logic [2:0]      wait_q, wait_d;
    logic            write_q;
    logic [1:0]      size_q;
    logic [IdxW+1:0] addr_q;
    logic            accept;
    logic            addr_err;
    logic [3:0]      be;
    logic [31:0]     mem_rdata;
    logic            unused_inputs;

    // Burst type carries no information since every beat brings its own address.
    assign unused_inputs = ^{HBURST, HTRANS[0]};

    assign accept   = HSEL && HREADY && HTRANS[1];
    assign addr_err = ({1'b0, HADDR} >= ByteLimit) || (HSIZE > SizeWord) ||
                      ((HSIZE == SizeHalf) && HADDR[0]) ||
                      ((HSIZE == SizeWord) && (HADDR[1:0] != 2'b00));

    // Next data phase: count down wait states, always run both error cycles.
    always_comb begin
        phase_d = phase_q;
        wait_d  = wait_q;
        unique case (phase_q)
            StWait: begin
                if (wait_q <= 3'd1) begin
                    phase_d = StOkayDone;
                end else begin
                    wait_d = wait_q - 3'd1;
                end
            end
            StErr1: phase_d = StErr2;
            default: begin
                if (!accept) begin
                    phase_d = StIdle;
                end else if (addr_err) begin
                    phase_d = StErr1;
                end else if (WAIT_STATES == 0) begin
                    phase_d = StOkayDone;
                end else begin
                    phase_d = StWait;
                    wait_d  = WaitLoad;
                end
            end
        endcase
    end

    // Phase register plus address-phase controls held for the whole data phase.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            phase_q <= StIdle;
            wait_q  <= '0;
            write_q <= 1'b0;
            size_q  <= '0;
            addr_q  <= '0;
        end else begin
            phase_q <= phase_d;
            wait_q  <= wait_d;
            if (accept) begin
                write_q <= HWRITE;
                size_q  <= HSIZE[1:0];
                addr_q  <= HADDR[IdxW+1:0];
            end
        end
    end

    assign HREADY = !((phase_q == StWait) || (phase_q == StErr1));
    assign HRESP  = ((phase_q == StErr1) || (phase_q == StErr2)) ? RespError : RespOkay;
    assign HRDATA = ((phase_q == StOkayDone) && !write_q) ? mem_rdata : 32'h0;
    assign be     = ((phase_q == StOkayDone) && write_q) ? lane_mask(size_q, addr_q[1:0])
                                                        : 4'b0000;

    ahb_slave_mem #(
        .Words (MEM_WORDS),
        .IdxW  (IdxW)
    ) u_mem (
        .clk_i   (HCLK),
        .clear_i (HRESET),
        .be_i    (be),
        .addr_i  (addr_q[IdxW+1:2]),
        .wdata_i (HWDATA),
        .rdata_o (mem_rdata)
    );

endmodule

// File: tb/tb_modport_slave.sv
// Self-checking bench: two slaves (zero and two wait states) share one bus; HSEL is steered
// to the slave under test. A byte-array model predicts responses and read data.
module tb_modport_slave;

    localparam int unsigned MW     = 256;
    localparam int unsigned NBYTES = 4 * MW;

    logic        HCLK = 1'b0;
    logic        HRESET, HSEL, HWRITE;
    logic [1:0]  HTRANS;
    logic [2:0]  HBURST, HSIZE;
    logic [31:0] HADDR, HWDATA;
    logic        tgt;
    logic        hsel0, hsel1, ready0, ready1, hready;
    logic [1:0]  resp0, resp1, hresp;
    logic [31:0] rdata0, rdata1, hrdata;

    int checks = 0;
    int errors = 0;
    logic [7:0]  mem_m [2][NBYTES];
    logic [31:0] bdata [4];

    always #5 HCLK = ~HCLK;

    assign hsel0  = HSEL && !tgt;
    assign hsel1  = HSEL && tgt;
    assign hready = tgt ? ready1 : ready0;
    assign hresp  = tgt ? resp1 : resp0;
    assign hrdata = tgt ? rdata1 : rdata0;

    modport_slave #(.MEM_WORDS(MW), .WAIT_STATES(0)) dut0 (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel0), .HTRANS(HTRANS), .HBURST(HBURST),
        .HSIZE(HSIZE), .HWRITE(HWRITE), .HADDR(HADDR), .HWDATA(HWDATA),
        .HRDATA(rdata0), .HREADY(ready0), .HRESP(resp0)
    );

    modport_slave #(.MEM_WORDS(MW), .WAIT_STATES(2)) dut1 (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel1), .HTRANS(HTRANS), .HBURST(HBURST),
        .HSIZE(HSIZE), .HWRITE(HWRITE), .HADDR(HADDR), .HWDATA(HWDATA),
        .HRDATA(rdata1), .HREADY(ready1), .HRESP(resp1)
    );

    typedef struct {
        logic        wr;
        logic [2:0]  sz;
        logic [31:0] addr;
        logic [31:0] wd;
        int          lows;
        logic [1:0]  resp;
        logic [31:0] rd;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic bit m_err(input logic [2:0] sz, input logic [31:0] a);
        return (a >= NBYTES) || (sz > 3'd2) || (sz == 3'd1 && a[0]) ||
               (sz == 3'd2 && a[1:0] != 2'b00);
    endfunction

    function automatic logic [31:0] m_word(input int d, input logic [31:0] a);
        logic [31:0] w;
        int base;
        base = int'(a) & ~3;
        for (int b = 0; b < 4; b++) w[8*b +: 8] = mem_m[d][base + b];
        return w;
    endfunction

    task automatic m_write(input int d, input logic [2:0] sz, input logic [31:0] a,
                           input logic [31:0] wd);
        int n;
        int ba;
        n = 1 << sz;
        for (int b = 0; b < n; b++) begin
            ba = int'(a) + b;
            mem_m[d][ba] = wd[8*(ba % 4) +: 8];
        end
    endtask

    task automatic m_clear();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < int'(NBYTES); i++) mem_m[d][i] = 8'h00;
    endtask

    task automatic idle_bus();
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        HADDR  = 32'h0;
        HWRITE = 1'b0;
        HSIZE  = 3'd0;
        HBURST = 3'd0;
    endtask

    // One non-pipelined transfer; garbage is driven on the address bus while HREADY is low.
    task automatic xfer(input string tag, input logic wr, input logic [2:0] sz,
                        input logic [31:0] a, input logic [31:0] wd, input int exp_lows,
                        input logic [1:0] exp_resp, input logic [31:0] exp_rd);
        int lows;
        @(negedge HCLK);
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = a; HWRITE = wr; HSIZE = sz;
        @(negedge HCLK);
        HWDATA = wd;
        idle_bus();
        lows = 0;
        while (!hready && lows < 20) begin
            chk({tag, "_waitresp"}, 32'(hresp), 32'(exp_resp));
            HSEL = 1'b1; HTRANS = 2'b10; HADDR = $urandom;
            HWRITE = 1'($urandom); HSIZE = 3'($urandom);
            lows++;
            @(negedge HCLK);
        end
        idle_bus();
        chk({tag, "_lows"}, 32'(lows), 32'(exp_lows));
        chk({tag, "_resp"}, 32'(hresp), 32'(exp_resp));
        if (!wr) chk({tag, "_rdata"}, hrdata, exp_rd);
        if (wr && !m_err(sz, a)) m_write(int'(tgt), sz, a, wd);
    endtask

    // Four-beat pipelined word burst on the selected slave; the next address is held during waits.
    task automatic burst4(input string tag, input logic wr, input logic [31:0] base,
                          input int exp_lows);
        int lows;
        logic [31:0] ea;
        @(negedge HCLK);
        HSEL = 1'b1; HTRANS = 2'b10; HBURST = 3'b011; HADDR = base; HWRITE = wr; HSIZE = 3'd2;
        @(negedge HCLK);
        for (int i = 0; i < 4; i++) begin
            ea = base + 32'(4 * i);
            if (wr) HWDATA = bdata[i];
            if (i < 3) begin
                HTRANS = 2'b11;
                HADDR  = base + 32'(4 * (i + 1));
            end else begin
                idle_bus();
            end
            lows = 0;
            while (!hready && lows < 20) begin
                lows++;
                @(negedge HCLK);
            end
            chk({tag, "_lows"}, 32'(lows), 32'(exp_lows));
            chk({tag, "_resp"}, 32'(hresp), 32'h0);
            if (!wr) chk({tag, "_rdata"}, hrdata, m_word(int'(tgt), ea));
            if (wr) m_write(int'(tgt), 3'd2, ea, bdata[i]);
            @(negedge HCLK);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic        wr;
        logic [2:0]  sz;
        logic [31:0] a;
        bit          e;

        tgt = 1'b0; HWDATA = 32'h0; HRESET = 1'b1;
        idle_bus();
        m_clear();
        repeat (3) @(negedge HCLK);
        chk("rst_ready0", 32'(ready0), 32'h1);
        chk("rst_resp0",  32'(resp0),  32'h0);
        chk("rst_rdata0", rdata0,      32'h0);
        chk("rst_ready1", 32'(ready1), 32'h1);
        chk("rst_resp1",  32'(resp1),  32'h0);
        HRESET = 1'b0;

        // Directed table on the zero-wait slave.
        vecs.push_back('{1'b1, 3'd2, 32'h010, 32'hDEADBEEF, 0, 2'b00, 32'h0});
        vecs.push_back('{1'b0, 3'd2, 32'h010, 32'h0,        0, 2'b00, 32'hDEADBEEF});
        vecs.push_back('{1'b1, 3'd0, 32'h011, 32'h0000AA00, 0, 2'b00, 32'h0});
        vecs.push_back('{1'b0, 3'd2, 32'h010, 32'h0,        0, 2'b00, 32'hDEADAAEF});
        vecs.push_back('{1'b0, 3'd2, 32'h002, 32'h0,        1, 2'b01, 32'h0});
        vecs.push_back('{1'b1, 3'd2, 32'h400, 32'h12345678, 1, 2'b01, 32'h0});
        vecs.push_back('{1'b0, 3'd2, 32'h000, 32'h0,        0, 2'b00, 32'h0});
        vecs.push_back('{1'b1, 3'd1, 32'h012, 32'hBEEF0000, 0, 2'b00, 32'h0});
        vecs.push_back('{1'b0, 3'd2, 32'h010, 32'h0,        0, 2'b00, 32'hBEEFAAEF});
        vecs.push_back('{1'b0, 3'd1, 32'h012, 32'h0,        0, 2'b00, 32'hBEEFAAEF});
        vecs.push_back('{1'b0, 3'd0, 32'h011, 32'h0,        0, 2'b00, 32'hBEEFAAEF});
        vecs.push_back('{1'b0, 3'd1, 32'h013, 32'h0,        1, 2'b01, 32'h0});
        vecs.push_back('{1'b1, 3'd0, 32'h3FF, 32'h77000000, 0, 2'b00, 32'h0});
        vecs.push_back('{1'b0, 3'd2, 32'h3FC, 32'h0,        0, 2'b00, 32'h77000000});
        vecs.push_back('{1'b1, 3'd3, 32'h020, 32'hFFFFFFFF, 1, 2'b01, 32'h0});
        vecs.push_back('{1'b0, 3'd2, 32'h020, 32'h0,        0, 2'b00, 32'h0});
        foreach (vecs[i]) begin
            xfer($sformatf("vec%0d", i), vecs[i].wr, vecs[i].sz, vecs[i].addr, vecs[i].wd,
                 vecs[i].lows, vecs[i].resp, vecs[i].rd);
        end

        // Write data phase immediately followed by a read of the same word.
        @(negedge HCLK);
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h60; HWRITE = 1'b1; HSIZE = 3'd2;
        @(negedge HCLK);
        HWDATA = 32'hA5A51234; HWRITE = 1'b0;
        chk("pipe_wready", 32'(hready), 32'h1);
        @(negedge HCLK);
        idle_bus();
        chk("pipe_rready", 32'(hready), 32'h1);
        chk("pipe_rdata", hrdata, 32'hA5A51234);
        m_write(0, 3'd2, 32'h60, 32'hA5A51234);

        // NONSEQ, BUSY, unselected SEQ, IDLE.
        @(negedge HCLK);
        HSEL = 1'b1; HTRANS = 2'b10; HBURST = 3'b001; HADDR = 32'h50; HWRITE = 1'b1; HSIZE = 3'd2;
        @(negedge HCLK);
        HWDATA = 32'h11112222; HTRANS = 2'b01; HADDR = 32'h54;
        chk("seq_nonseq_ready", 32'(hready), 32'h1);
        chk("seq_nonseq_resp",  32'(hresp),  32'h0);
        @(negedge HCLK);
        HWDATA = 32'h33334444; HSEL = 1'b0; HTRANS = 2'b11; HADDR = 32'h54;
        chk("seq_busy_ready", 32'(hready), 32'h1);
        chk("seq_busy_resp",  32'(hresp),  32'h0);
        @(negedge HCLK);
        HWDATA = 32'h55556666; HSEL = 1'b1; HTRANS = 2'b00; HADDR = 32'h58;
        chk("seq_unsel_ready", 32'(hready), 32'h1);
        chk("seq_unsel_resp",  32'(hresp),  32'h0);
        @(negedge HCLK);
        idle_bus();
        chk("seq_idle_ready", 32'(hready), 32'h1);
        chk("seq_idle_resp",  32'(hresp),  32'h0);
        m_write(0, 3'd2, 32'h50, 32'h11112222);
        xfer("seq_rd50", 1'b0, 3'd2, 32'h50, 32'h0, 0, 2'b00, 32'h11112222);
        xfer("seq_rd54", 1'b0, 3'd2, 32'h54, 32'h0, 0, 2'b00, 32'h0);
        xfer("seq_rd58", 1'b0, 3'd2, 32'h58, 32'h0, 0, 2'b00, 32'h0);

        // INCR4 on the two-wait-state slave.
        tgt = 1'b1;
        bdata[0] = 32'h01020304; bdata[1] = 32'hA0B0C0D0;
        bdata[2] = 32'hFFFF0000; bdata[3] = 32'h13579BDF;
        burst4("burst_wr", 1'b1, 32'h20, 2);
        burst4("burst_rd", 1'b0, 32'h20, 2);
        xfer("burst_rd2c", 1'b0, 3'd2, 32'h2C, 32'h0, 2, 2'b00, 32'h13579BDF);

        // Randomized traffic against the model on both slaves.
        for (int n = 0; n < 200; n++) begin
            tgt = 1'(n % 2);
            wr  = 1'($urandom);
            sz  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            case ($urandom_range(0, 7))
                0:       a = NBYTES + 32'($urandom_range(0, 255));
                1, 2:    a = 32'($urandom_range(NBYTES - 16, NBYTES - 1));
                default: a = 32'($urandom_range(0, 63));
            endcase
            e = m_err(sz, a);
            xfer("rand", wr, sz, a, $urandom, e ? 1 : (tgt ? 2 : 0), e ? 2'b01 : 2'b00,
                 e ? 32'h0 : m_word(int'(tgt), a));
        end

        // Reset in the middle of a write data phase.
        tgt = 1'b0;
        @(negedge HCLK);
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h40; HWRITE = 1'b1; HSIZE = 3'd2;
        @(negedge HCLK);
        HWDATA = 32'hCAFEF00D;
        idle_bus();
        HRESET = 1'b1;
        @(negedge HCLK);
        HRESET = 1'b0;
        chk("midrst_ready", 32'(hready), 32'h1);
        chk("midrst_resp",  32'(hresp),  32'h0);
        chk("midrst_rdata", hrdata,      32'h0);
        m_clear();
        xfer("midrst_rd40", 1'b0, 3'd2, 32'h40, 32'h0, 0, 2'b00, 32'h0);
        xfer("midrst_rd10", 1'b0, 3'd2, 32'h10, 32'h0, 0, 2'b00, 32'h0);
        tgt = 1'b1;
        xfer("midrst_rd20", 1'b0, 3'd2, 32'h20, 32'h0, 2, 2'b00, 32'h0);

        repeat (2) @(negedge HCLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
